// File: rtl/sradd_reg.sv
// sradd_reg: two-stage pipelined FP32 adder (no denormals, NaN on overflow, flush-to-zero on underflow).
// Define SRADD_ROUND_EN for round-to-nearest-even after normalization; otherwise results are truncated.
module sradd_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   output logic [31:0] z
);
   logic        v1_q;
   logic        spec1_q, spec1_d;
   logic [31:0] sval1_q, sval1_d;
   logic        sign1_q, sign1_d;
   logic [7:0]  exp1_q, exp1_d;
   logic [27:0] sum1_q, sum1_d;
   logic        out_valid_q;
   logic [31:0] z_q, z_d;

   logic [31:0] lg_s, sm_s;
   logic [7:0]  ediff_s;
   logic [26:0] lx_s, sx_s, sx_al_s;
   logic        sticky_s;

   // Stage 1: order operands by magnitude, align the smaller one, add or subtract, flag special cases.
   always_comb begin
      if (a[30:0] >= b[30:0]) begin
         lg_s = a;
         sm_s = b;
      end else begin
         lg_s = b;
         sm_s = a;
      end
      ediff_s  = lg_s[30:23] - sm_s[30:23];
      lx_s     = {1'b1, lg_s[22:0], 3'b000};
      sx_s     = {1'b1, sm_s[22:0], 3'b000};
      sticky_s = |(sx_s & ~({27{1'b1}} << ediff_s));
      sx_al_s  = (sx_s >> ediff_s) | {26'd0, sticky_s};
      if (lg_s[31] == sm_s[31]) begin
         sum1_d = {1'b0, lx_s} + {1'b0, sx_al_s};
      end else begin
         sum1_d = {1'b0, lx_s} - {1'b0, sx_al_s};
      end
      sign1_d = lg_s[31];
      exp1_d  = lg_s[30:23];
      spec1_d = 1'b1;
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
         sval1_d = 32'hFFFF_FFFF;
      end else if (a[30:23] == 8'h00 && b[30:23] == 8'h00) begin
         sval1_d = 32'h0000_0000;
      end else if (a[30:23] == 8'h00) begin
         sval1_d = b;
      end else if (b[30:23] == 8'h00) begin
         sval1_d = a;
      end else if (ediff_s > 8'd24) begin
         sval1_d = lg_s;
      end else if (a[30:0] == b[30:0] && a[31] != b[31]) begin
         sval1_d = 32'h0000_0000;
      end else begin
         spec1_d = 1'b0;
         sval1_d = 32'h0000_0000;
      end
   end

   logic [4:0]        lzc_s;
   logic [26:0]       norm_s;
   logic [22:0]       mant_s, mant_r_s;
   logic              g_s, r_s, st_s;
   logic signed [9:0] exp_s, exp_r_s;

   // Stage 2: normalize (carry or leading-zero shift), optionally round, then range-check and pack.
   always_comb begin
      lzc_s = 5'd0;
      for (int i = 0; i < 27; i++) begin
         lzc_s = sum1_q[i] ? 5'(26 - i) : lzc_s;
      end
      norm_s = sum1_q[26:0] << lzc_s;
      if (sum1_q[27]) begin
         mant_s = sum1_q[26:4];
         g_s    = sum1_q[3];
         r_s    = sum1_q[2];
         st_s   = |sum1_q[1:0];
         exp_s  = $signed({2'b00, exp1_q}) + 10'sd1;
      end else begin
         mant_s = norm_s[25:3];
         g_s    = norm_s[2];
         r_s    = norm_s[1];
         st_s   = norm_s[0];
         exp_s  = $signed({2'b00, exp1_q}) - $signed({5'b00000, lzc_s});
      end
`ifdef SRADD_ROUND_EN
      begin
         logic rnd_s;
         logic mc_s;
         rnd_s = g_s & (r_s | st_s | mant_s[0]);
         {mc_s, mant_r_s} = {1'b0, mant_s} + {23'd0, rnd_s};
         exp_r_s = mc_s ? exp_s + 10'sd1 : exp_s;
      end
`else
      mant_r_s = mant_s;
      exp_r_s  = exp_s;
`endif
      if (spec1_q) begin
         z_d = sval1_q;
      end else if (exp_r_s > 10'sd254) begin
         z_d = 32'hFFFF_FFFF;
      end else if (exp_r_s < 10'sd1) begin
         z_d = 32'h0000_0000;
      end else begin
         z_d = {sign1_q, exp_r_s[7:0], mant_r_s};
      end
   end

   // The hidden bit after normalization is always 1; guard bits matter only when rounding.
   logic unused_s;
`ifdef SRADD_ROUND_EN
   assign unused_s = norm_s[26];
`else
   assign unused_s = ^{norm_s[26], g_s, r_s, st_s};
`endif

   // Pipeline registers; reset wins and drops anything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q        <= 1'b0;
         spec1_q     <= 1'b0;
         sval1_q     <= 32'h0000_0000;
         sign1_q     <= 1'b0;
         exp1_q      <= 8'h00;
         sum1_q      <= 28'h000_0000;
         out_valid_q <= 1'b0;
         z_q         <= 32'h0000_0000;
      end else begin
         v1_q <= in_valid;
         if (in_valid) begin
            spec1_q <= spec1_d;
            sval1_q <= sval1_d;
            sign1_q <= sign1_d;
            exp1_q  <= exp1_d;
            sum1_q  <= sum1_d;
         end
         out_valid_q <= v1_q;
         if (v1_q) begin
            z_q <= z_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign z         = z_q;
endmodule

// File: tb/tb_sradd_reg.sv
// Self-checking bench for sradd_reg: directed vectors plus random operands against an exact-arithmetic model.
module tb_sradd_reg;
   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] a, b;
   logic        out_valid;
   logic [31:0] z;

   int checks   = 0;
   int failures = 0;

   logic [1:0]  dl_v;
   logic [31:0] dl_z0, dl_z1, last_z;

`ifdef SRADD_ROUND_EN
   localparam logic [31:0] SQRT_SUM = 32'h3FDA_827A;
`else
   localparam logic [31:0] SQRT_SUM = 32'h3FDA_8279;
`endif

   sradd_reg dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
      .out_valid(out_valid), .z(z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Exact sum of the two operands as integers scaled by the smaller exponent, then cut to 24 bits.
   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] l, s;
      int          d, p, e;
      longint      v, m, rem, half;
      if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return 32'hFFFF_FFFF;
      if (x[30:23] == 8'h00 && y[30:23] == 8'h00) return 32'h0000_0000;
      if (x[30:23] == 8'h00) return y;
      if (y[30:23] == 8'h00) return x;
      if (x[30:0] >= y[30:0]) begin l = x; s = y; end
      else begin l = y; s = x; end
      d = int'(l[30:23]) - int'(s[30:23]);
      if (d > 24) return l;
      if (l[31] == s[31]) v = (longint'({1'b1, l[22:0]}) << d) + longint'({1'b1, s[22:0]});
      else                v = (longint'({1'b1, l[22:0]}) << d) - longint'({1'b1, s[22:0]});
      if (v == 0) return 32'h0000_0000;
      p = 0;
      for (int i = 0; i < 63; i++) if (v[i]) p = i;
      e = p + int'(s[30:23]) - 23;
      if (p >= 23) begin
         m   = v >> (p - 23);
         rem = v - (m << (p - 23));
      end else begin
         m   = v << (23 - p);
         rem = 0;
      end
`ifdef SRADD_ROUND_EN
      if (p > 23) begin
         half = longint'(1) << (p - 24);
         if (rem > half || (rem == half && m[0])) m = m + 1;
         if (m == (longint'(1) << 24)) begin m = m >> 1; e = e + 1; end
      end
`else
      half = rem;
`endif
      if (e > 254) return 32'hFFFF_FFFF;
      if (e < 1) return 32'h0000_0000;
      return {l[31], e[7:0], m[22:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock: apply inputs, advance past the edge, compare against the two-deep expected delay line.
   task automatic step(input logic r, input logic v, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e);
      rst = r; in_valid = v; a = x; b = y;
      @(posedge clk); #1;
      if (r) begin
         dl_v = 2'b00;
         last_z = 32'h0000_0000;
      end else begin
         dl_v  = {dl_v[0], v};
         dl_z1 = dl_z0;
         dl_z0 = e;
         if (dl_v[1]) last_z = dl_z1;
      end
      check("out_valid", {31'd0, out_valid}, {31'd0, dl_v[1]});
      check("z", z, last_z);
   endtask

   task automatic op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
      step(1'b0, 1'b1, x, y, e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      logic [31:0] x, y;
      logic [7:0]  ey;
      rst = 1'b1; in_valid = 1'b0; a = 32'h0; b = 32'h0;
      dl_v = 2'b00; dl_z0 = 32'h0; dl_z1 = 32'h0; last_z = 32'h0;
      step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      step(1'b1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h0);
      idle(2);

      op(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
      idle(3);
      op(32'h3F80_0000, 32'h3F35_04F3, SQRT_SUM);
      op(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
      op(32'h4040_0000, 32'hBF80_0000, 32'h4000_0000);
      op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'hFFFF_FFFF);
      op(32'h0080_0000, 32'h8000_0001, 32'h0080_0000);
      op(32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000);
      op(32'h7F80_0000, 32'h3F80_0000, 32'hFFFF_FFFF);
      op(32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
      op(32'h4C00_0000, 32'h3F80_0000, 32'h4C00_0000);
      op(32'h0080_0000, 32'h8080_0001, ref_add(32'h0080_0000, 32'h8080_0001));
      op(32'h3F80_0000, 32'hBF7F_FFFF, ref_add(32'h3F80_0000, 32'hBF7F_FFFF));
      idle(3);

      for (int i = 0; i < 8; i++) begin
         x = 32'h3F80_0000 + 32'(i) * 32'h0010_0000;
         y = 32'h4000_0000 + 32'(i);
         step(i == 2, 1'b1, x, y, ref_add(x, y));
      end
      idle(3);

      for (int i = 0; i < 400; i++) begin
         x = $urandom;
         case ($urandom_range(0, 5))
            0: y = $urandom;
            1: begin
               ey = x[30:23] - 8'($urandom_range(0, 3));
               y = {1'($urandom), ey, 23'($urandom)};
            end
            2: y = x ^ 32'h8000_0000;
            3: begin
               x = {x[31], 8'($urandom_range(1, 4)), x[22:0]};
               y = {~x[31], 8'($urandom_range(1, 4)), 23'($urandom)};
            end
            4: begin
               x = {x[31], 8'($urandom_range(250, 254)), x[22:0]};
               y = {x[31], 8'($urandom_range(250, 254)), 23'($urandom)};
            end
            default: y = {1'($urandom), 8'(x[30:23] - 8'($urandom_range(20, 27))), 23'($urandom)};
         endcase
         step(1'b0, $urandom_range(0, 7) != 0, x, y, ref_add(x, y));
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
